// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared states and constants for the IIC configuration-port responder
package iic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } iic_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // CH7301 DVI transmitter defaults
    localparam logic [6:0] CH7301_ADDR     = 7'h76;
    localparam logic [7:0] CH7301_ID_ADDR  = 8'h4B;
    localparam logic [7:0] CH7301_ID_VALUE = 8'h17;

endpackage

// File: rtl/iic_filter.sv
// rtl/iic_filter.sv - pad synchronizer, glitch filter and edge detector for one IIC line
module iic_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic fclk,
    input  logic fclk_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(FILT_LEN) + 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // Edge pulses are registered together with the level, so both are aligned.
    always_ff @(posedge fclk) begin
        if (fclk_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CW'(FILT_LEN - 1)) begin
                    r_level <= r_sync2;
                    r_rise  <= r_sync2;
                    r_fall  <= ~r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/iic_responder.sv
// rtl/iic_responder.sv - IIC target serving a byte-wide register file with auto-increment pointer
module iic_responder
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = CH7301_ADDR,
    parameter int         REG_DEPTH = 128,
    parameter logic [7:0] ID_ADDR   = CH7301_ID_ADDR,
    parameter logic [7:0] ID_VALUE  = CH7301_ID_VALUE,
    parameter int         FILT_LEN  = 4
) (
    input  logic       fclk,
    input  logic       fclk_rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;

    iic_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .fclk     (fclk),
        .fclk_rst (fclk_rst),
        .i_raw    (scl_in),
        .o_level  (w_scl),
        .o_rise   (w_scl_rise),
        .o_fall   (w_scl_fall)
    );

    iic_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .fclk     (fclk),
        .fclk_rst (fclk_rst),
        .i_raw    (sda_in),
        .o_level  (w_sda),
        .o_rise   (w_sda_rise),
        .o_fall   (w_sda_fall)
    );

    iic_state_t r_state, w_state_nxt;
    logic [6:0] r_shift, w_shift_nxt;
    logic [6:0] r_tx, w_tx_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_ack_drv, w_ack_drv_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_sda_oe, w_oe_nxt;
    logic [7:0] r_ptr, w_ptr_nxt;
    logic       r_wr_stb, w_stb_nxt;
    logic [7:0] r_wr_addr, w_waddr_nxt;
    logic [7:0] r_wr_data, w_wdata_nxt;
    logic       w_commit;
    logic [7:0] r_regs [REG_DEPTH];

    logic       w_start, w_stop, w_in_range;
    logic [7:0] w_rx_byte, w_rd_byte;

    assign w_start    = w_sda_fall & w_scl;
    assign w_stop     = w_sda_rise & w_scl;
    assign w_rx_byte  = {r_shift, w_sda};
    assign w_in_range = (int'(r_ptr) < REG_DEPTH);
    assign w_rd_byte  = (r_ptr == ID_ADDR) ? ID_VALUE :
                        w_in_range         ? r_regs[r_ptr[AW-1:0]] : 8'h00;

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_cnt_nxt     = r_cnt;
        w_ack_drv_nxt = r_ack_drv;
        w_rw_nxt      = r_rw;
        w_busy_nxt    = r_busy;
        w_oe_nxt      = r_sda_oe;
        w_ptr_nxt     = r_ptr;
        w_stb_nxt     = 1'b0;
        w_waddr_nxt   = r_wr_addr;
        w_wdata_nxt   = r_wr_data;
        w_commit      = 1'b0;
        // Bus conditions outrank any bit edge seen in the same cycle.
        if (w_start || w_stop) begin
            w_state_nxt   = w_start ? ST_DEV_ADDR : ST_IDLE;
            w_cnt_nxt     = 4'd0;
            w_busy_nxt    = 1'b0;
            w_oe_nxt      = 1'b0;
            w_ack_drv_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_rx_byte[6:0];
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            w_cnt_nxt = 4'd0;
                            if (r_state == ST_DEV_ADDR) begin
                                if (w_rx_byte[7:1] == DEV_ADDR) begin
                                    w_state_nxt = ST_DEV_ACK;
                                    w_busy_nxt  = 1'b1;
                                    w_rw_nxt    = w_rx_byte[0];
                                end else begin
                                    w_state_nxt = ST_IGNORE;
                                end
                            end else if (r_state == ST_REG_ADDR) begin
                                w_ptr_nxt   = w_rx_byte;
                                w_state_nxt = ST_REG_ACK;
                            end else begin
                                w_stb_nxt   = 1'b1;
                                w_waddr_nxt = r_ptr;
                                w_wdata_nxt = w_rx_byte;
                                w_commit    = w_in_range && (r_ptr != ID_ADDR);
                                w_ptr_nxt   = r_ptr + 8'd1;
                                w_state_nxt = ST_WR_ACK;
                            end
                        end
                    end
                end
                // First falling edge starts the ACK, second one ends it.
                ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_drv) begin
                            w_oe_nxt      = (ACK == 1'b0);
                            w_ack_drv_nxt = 1'b1;
                        end else begin
                            w_oe_nxt      = 1'b0;
                            w_ack_drv_nxt = 1'b0;
                            w_cnt_nxt     = 4'd0;
                            if (r_state == ST_DEV_ACK && r_rw) begin
                                w_state_nxt = ST_RD_DATA;
                                w_tx_nxt    = w_rd_byte[6:0];
                                w_oe_nxt    = ~w_rd_byte[7];
                            end else if (r_state == ST_DEV_ACK) begin
                                w_state_nxt = ST_REG_ADDR;
                            end else begin
                                w_state_nxt = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_oe_nxt    = 1'b0;
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = ST_RD_ACK;
                        end else begin
                            w_oe_nxt = ~r_tx[6];
                            w_tx_nxt = {r_tx[5:0], 1'b0};
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda == ACK) begin
                            w_ptr_nxt = r_ptr + 8'd1;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                        end
                    end else if (w_scl_fall) begin
                        w_state_nxt = ST_RD_DATA;
                        w_tx_nxt    = w_rd_byte[6:0];
                        w_oe_nxt    = ~w_rd_byte[7];
                        w_cnt_nxt   = 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge fclk) begin
        if (fclk_rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_tx      <= '0;
            r_cnt     <= '0;
            r_ack_drv <= 1'b0;
            r_rw      <= 1'b0;
            r_busy    <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_ptr     <= '0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ack_drv <= w_ack_drv_nxt;
            r_rw      <= w_rw_nxt;
            r_busy    <= w_busy_nxt;
            r_sda_oe  <= w_oe_nxt;
            r_ptr     <= w_ptr_nxt;
            r_wr_stb  <= w_stb_nxt;
            r_wr_addr <= w_waddr_nxt;
            r_wr_data <= w_wdata_nxt;
        end
    end

    always_ff @(posedge fclk) begin
        if (fclk_rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[r_ptr[AW-1:0]] <= w_rx_byte;
        end
    end

    assign sda_oe  = r_sda_oe;
    assign busy    = r_busy;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
